// File: rtl/rps_pkg.sv
// Shared encodings for the stone-paper-scissors match controller: FSM states,
// per-round result codes and match winner codes.
package rps_pkg;

  // Match controller states; the encoding is exported on state_o.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_RESULT = 2'd2,
    S_OVER   = 2'd3
  } state_e;

  // Per-round outcome codes driven on round_result.
  localparam logic [1:0] RES_TIE     = 2'b00;
  localparam logic [1:0] RES_P1      = 2'b01;
  localparam logic [1:0] RES_P2      = 2'b10;
  localparam logic [1:0] RES_INVALID = 2'b11;

  // Match outcome codes driven on match_winner.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge for generalised stone-paper-scissors with an odd
// number of moves. Move m1 beats m2 when (m1 - m2) mod NUM_MOVES lies in the
// lower half of the non-zero residues.
module rps_judge
  import rps_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 3,
  parameter int unsigned MOVE_W    = 2
) (
  input  logic [MOVE_W-1:0] m1,
  input  logic [MOVE_W-1:0] m2,
  output logic [1:0]        result
);

  // One spare bit so NUM_MOVES and a + NUM_MOVES - b never overflow.
  localparam logic [MOVE_W:0] NumW  = NUM_MOVES[MOVE_W:0];
  localparam int unsigned     Half  = (NUM_MOVES - 1) / 2;
  localparam logic [MOVE_W:0] HalfW = Half[MOVE_W:0];

  logic [MOVE_W:0] a;
  logic [MOVE_W:0] b;
  logic [MOVE_W:0] diff;

  // Modular difference without a divider: operands are already < NUM_MOVES
  // on the valid path, so a single conditional add of NUM_MOVES suffices.
  always_comb begin
    a = {1'b0, m1};
    b = {1'b0, m2};
    if (a >= b) begin
      diff = a - b;
    end else begin
      diff = a + NumW - b;
    end

    if ((a >= NumW) || (b >= NumW)) begin
      result = RES_INVALID;
    end else if (diff == '0) begin
      result = RES_TIE;
    end else if (diff <= HalfW) begin
      result = RES_P1;
    end else begin
      result = RES_P2;
    end
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// Best-of-N match controller: captures both moves on a start rising edge,
// judges the round, keeps scores and a counted-round total, and declares the
// match winner on reaching WIN_TARGET points or MAX_ROUNDS counted rounds.
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int unsigned NUM_MOVES  = 3,
  parameter int unsigned MOVE_W     = 2,
  parameter int unsigned WIN_TARGET = 3,
  parameter int unsigned MAX_ROUNDS = 9,
  parameter int unsigned SCORE_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [MOVE_W-1:0]  p1_move,
  input  logic [MOVE_W-1:0]  p2_move,
  input  logic               start,
  input  logic               clear_match,
  output logic [1:0]         round_result,
  output logic               result_valid,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [SCORE_W-1:0] round_cnt,
  output logic               match_over,
  output logic [1:0]         match_winner,
  output logic [1:0]         state_o
);

  localparam logic [SCORE_W-1:0] WinTarget = WIN_TARGET[SCORE_W-1:0];
  localparam logic [SCORE_W-1:0] MaxRounds = MAX_ROUNDS[SCORE_W-1:0];
  localparam logic [SCORE_W-1:0] ScoreOne  = SCORE_W'(1);

  state_e             state_q;
  logic               start_q;
  logic [MOVE_W-1:0]  m1_q;
  logic [MOVE_W-1:0]  m2_q;
  logic [1:0]         res_q;
  logic               valid_q;
  logic [SCORE_W-1:0] p1_q;
  logic [SCORE_W-1:0] p2_q;
  logic [SCORE_W-1:0] rc_q;
  logic               over_q;
  logic [1:0]         win_q;

  logic               start_rise;
  logic [1:0]         judge_res;
  logic [SCORE_W-1:0] p1_n;
  logic [SCORE_W-1:0] p2_n;
  logic [SCORE_W-1:0] rc_n;
  logic               end_n;
  logic [1:0]         win_n;

  // ena gates the edge so a press while disabled is never seen.
  assign start_rise = start & ~start_q & ena;

  rps_judge #(
    .NUM_MOVES (NUM_MOVES),
    .MOVE_W    (MOVE_W)
  ) u_judge (
    .m1     (m1_q),
    .m2     (m2_q),
    .result (judge_res)
  );

  // Score update and end-of-match decision for the round being evaluated.
  always_comb begin
    p1_n  = p1_q;
    p2_n  = p2_q;
    rc_n  = rc_q;
    end_n = 1'b0;
    win_n = WIN_NONE;

    unique case (judge_res)
      RES_TIE: begin
        rc_n = rc_q + ScoreOne;
      end
      RES_P1: begin
        p1_n = p1_q + ScoreOne;
        rc_n = rc_q + ScoreOne;
      end
      RES_P2: begin
        p2_n = p2_q + ScoreOne;
        rc_n = rc_q + ScoreOne;
      end
      default: begin
        // Invalid move: counters stay put, so the match cannot end here.
      end
    endcase

    if (judge_res != RES_INVALID) begin
      if (p1_n == WinTarget) begin
        end_n = 1'b1;
        win_n = WIN_P1;
      end else if (p2_n == WinTarget) begin
        end_n = 1'b1;
        win_n = WIN_P2;
      end else if (rc_n == MaxRounds) begin
        end_n = 1'b1;
        if (p1_n > p2_n) begin
          win_n = WIN_P1;
        end else if (p2_n > p1_n) begin
          win_n = WIN_P2;
        end else begin
          win_n = WIN_NONE;
        end
      end
    end
  end

  // Match FSM with registered outputs; clear_match overrides any round activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      m1_q    <= '0;
      m2_q    <= '0;
      res_q   <= RES_TIE;
      valid_q <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
      rc_q    <= '0;
      over_q  <= 1'b0;
      win_q   <= WIN_NONE;
    end else if (ena) begin
      start_q <= start;
      valid_q <= 1'b0;
      if (clear_match) begin
        state_q <= S_IDLE;
        res_q   <= RES_TIE;
        p1_q    <= '0;
        p2_q    <= '0;
        rc_q    <= '0;
        over_q  <= 1'b0;
        win_q   <= WIN_NONE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_rise) begin
              m1_q    <= p1_move;
              m2_q    <= p2_move;
              state_q <= S_EVAL;
            end
          end
          S_EVAL: begin
            res_q   <= judge_res;
            valid_q <= 1'b1;
            p1_q    <= p1_n;
            p2_q    <= p2_n;
            rc_q    <= rc_n;
            if (end_n) begin
              state_q <= S_OVER;
              over_q  <= 1'b1;
              win_q   <= win_n;
            end else begin
              state_q <= S_RESULT;
            end
          end
          S_RESULT: begin
            // Wait for release so a held button yields exactly one round.
            if (!start) begin
              state_q <= S_IDLE;
            end
          end
          S_OVER: begin
            // Terminal until clear_match or reset.
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign round_result = res_q;
  assign result_valid = valid_q;
  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign round_cnt    = rc_q;
  assign match_over   = over_q;
  assign match_winner = win_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Randomised scoreboard bench for rps_match_ctrl: a rule-level match model
// queues the expected response of every round, and monitors pop and compare
// whenever a DUT raises result_valid.
module tb_rps_match_ctrl;

  typedef struct {
    int res;
    int p1;
    int p2;
    int rc;
    int over;
    int win;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;

  // Three-move instance (default parameters)
  logic [1:0] p1_move = '0;
  logic [1:0] p2_move = '0;
  logic       start = 1'b0;
  logic       clear_match = 1'b0;
  logic [1:0] round_result;
  logic       result_valid;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [3:0] round_cnt;
  logic       match_over;
  logic [1:0] match_winner;
  logic [1:0] state_o;

  // Five-move instance
  logic [2:0] p1_move5 = '0;
  logic [2:0] p2_move5 = '0;
  logic       start5 = 1'b0;
  logic       clear5 = 1'b0;
  logic [1:0] round_result5;
  logic       result_valid5;
  logic [3:0] p1_score5;
  logic [3:0] p2_score5;
  logic [3:0] round_cnt5;
  logic       match_over5;
  logic [1:0] match_winner5;
  logic [1:0] state_o5;

  int checks = 0;
  int errors = 0;

  exp_t q3[$];
  int   q5[$];

  // Reference model state
  int m_p1 = 0;
  int m_p2 = 0;
  int m_rc = 0;
  int m_over = 0;
  int m_win = 0;

  localparam int WinTarget = 3;
  localparam int MaxRounds = 9;

  always #5 clk = ~clk;

  rps_match_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .p1_move      (p1_move),
    .p2_move      (p2_move),
    .start        (start),
    .clear_match  (clear_match),
    .round_result (round_result),
    .result_valid (result_valid),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .round_cnt    (round_cnt),
    .match_over   (match_over),
    .match_winner (match_winner),
    .state_o      (state_o)
  );

  rps_match_ctrl #(
    .NUM_MOVES  (5),
    .MOVE_W     (3),
    .WIN_TARGET (3),
    .MAX_ROUNDS (9),
    .SCORE_W    (4)
  ) u_dut5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .p1_move      (p1_move5),
    .p2_move      (p2_move5),
    .start        (start5),
    .clear_match  (clear5),
    .round_result (round_result5),
    .result_valid (result_valid5),
    .p1_score     (p1_score5),
    .p2_score     (p2_score5),
    .round_cnt    (round_cnt5),
    .match_over   (match_over5),
    .match_winner (match_winner5),
    .state_o      (state_o5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round outcome straight from the game rules.
  function automatic int ref_judge(input int a, input int b, input int n);
    int d;
    if (a >= n || b >= n) return 3;
    d = (a - b + n) % n;
    if (d == 0) return 0;
    if (d <= (n - 1) / 2) return 1;
    return 2;
  endfunction

  task automatic model_round(input int r);
    exp_t e;
    if (m_over != 0) return;
    if (r != 3) begin
      m_rc++;
      if (r == 1) m_p1++;
      if (r == 2) m_p2++;
      if (m_p1 == WinTarget) begin
        m_over = 1; m_win = 1;
      end else if (m_p2 == WinTarget) begin
        m_over = 1; m_win = 2;
      end else if (m_rc == MaxRounds) begin
        m_over = 1;
        m_win = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 0;
      end
    end
    e.res = r; e.p1 = m_p1; e.p2 = m_p2; e.rc = m_rc; e.over = m_over; e.win = m_win;
    q3.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (q3.size() == 0 && q5.size() == 0) return;
      @(negedge clk);
    end
    chk({name, "_drain_pending"}, q3.size() + q5.size(), 0);
    q3.delete();
    q5.delete();
  endtask

  // Press start for 'hold' cycles with the given moves, then release.
  task automatic do_round(input int a, input int b, input int hold);
    p1_move = 2'(a);
    p2_move = 2'(b);
    start = 1'b1;
    model_round(ref_judge(a, b, 3));
    repeat (hold) @(negedge clk);
    p1_move = 2'($urandom);
    p2_move = 2'($urandom);
    start = 1'b0;
    repeat (3) @(negedge clk);
    drain("round");
  endtask

  task automatic do_clear();
    clear_match = 1'b1;
    @(negedge clk);
    clear_match = 1'b0;
    m_p1 = 0; m_p2 = 0; m_rc = 0; m_over = 0; m_win = 0;
    chk("clear_p1", p1_score, 0);
    chk("clear_rc", round_cnt, 0);
    chk("clear_over", match_over, 0);
    chk("clear_state", state_o, 0);
  endtask

  task automatic do_round5(input int a, input int b);
    clear5 = 1'b1;
    @(negedge clk);
    clear5 = 1'b0;
    p1_move5 = 3'(a);
    p2_move5 = 3'(b);
    start5 = 1'b1;
    q5.push_back(ref_judge(a, b, 5));
    @(negedge clk);
    start5 = 1'b0;
    repeat (3) @(negedge clk);
    drain("round5");
  endtask

  // Scoreboard monitor for the three-move instance.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (q3.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("round_result", round_result, e.res);
        chk("p1_score", p1_score, e.p1);
        chk("p2_score", p2_score, e.p2);
        chk("round_cnt", round_cnt, e.rc);
        chk("match_over", match_over, e.over);
        chk("match_winner", match_winner, e.win);
        chk("state_after_eval", state_o, (e.over != 0) ? 3 : 2);
      end
    end
  end

  // Scoreboard monitor for the five-move instance.
  always @(negedge clk) begin
    if (rst_n && result_valid5) begin
      if (q5.size() == 0) begin
        chk("unexpected_valid5", 1, 0);
      end else begin
        int r;
        r = q5.pop_front();
        chk("round_result5", round_result5, r);
      end
    end
  end

  initial begin
    int r;
    // Reset values
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_scores", {p1_score, p2_score, round_cnt}, 0);
    chk("rst_match", {match_over, match_winner, round_result}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All 16 move pairs, clearing whenever a match ends
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        if (m_over != 0) do_clear();
        do_round(a, b, 1);
      end
    end

    // P1 wins three straight; later presses are ignored
    do_clear();
    do_round(1, 0, 1);
    do_round(2, 1, 1);
    do_round(0, 2, 1);
    chk("p1win_score", p1_score, 3);
    chk("p1win_rc", round_cnt, 3);
    chk("p1win_over", match_over, 1);
    chk("p1win_winner", match_winner, 1);
    do_round(0, 1, 2);
    chk("over_ignores_p2", p2_score, 0);
    chk("over_state", state_o, 3);

    // 2-2 plus five ties ends on the round limit as a draw; invalid is not counted
    do_clear();
    do_round(1, 0, 1);
    do_round(0, 1, 1);
    do_round(2, 1, 1);
    do_round(1, 2, 1);
    do_round(3, 0, 1);
    chk("invalid_rc", round_cnt, 4);
    for (int i = 0; i < 5; i++) do_round(i % 3, i % 3, 1);
    chk("maxr_over", match_over, 1);
    chk("maxr_winner", match_winner, 0);
    chk("maxr_rc", round_cnt, 9);

    // Held start yields one round; re-press yields another
    do_clear();
    do_round(0, 0, 20);
    chk("hold_rc", round_cnt, 1);
    do_round(0, 0, 2);
    chk("repress_rc", round_cnt, 2);

    // Start while disabled does nothing
    ena = 1'b0;
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    chk("ena_rc", round_cnt, 2);
    chk("ena_state", state_o, 0);

    // clear_match during evaluation discards the round
    do_round(1, 0, 1);
    p1_move = 2'd2;
    p2_move = 2'd0;
    start = 1'b1;
    @(negedge clk);
    chk("eval_state", state_o, 1);
    clear_match = 1'b1;
    @(negedge clk);
    clear_match = 1'b0;
    start = 1'b0;
    m_p1 = 0; m_p2 = 0; m_rc = 0; m_over = 0; m_win = 0;
    chk("clr_eval_valid", result_valid, 0);
    chk("clr_eval_scores", {p1_score, p2_score, round_cnt}, 0);
    chk("clr_eval_state", state_o, 0);
    repeat (3) @(negedge clk);

    // Randomised play
    for (int i = 0; i < 60; i++) begin
      if (m_over != 0 && $urandom_range(0, 2) != 0) do_clear();
      do_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(1, 4)));
    end

    // Five-move rules, all 64 code pairs
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        do_round5(a, b);
      end
    end

    // Asynchronous reset while in the result state
    do_clear();
    p1_move = 2'd1;
    p2_move = 2'd0;
    start = 1'b1;
    model_round(ref_judge(1, 0, 3));
    repeat (2) @(negedge clk);
    chk("pre_rst_state", state_o, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", state_o, 0);
    chk("async_rst_scores", {p1_score, p2_score, round_cnt}, 0);
    chk("async_rst_match", {match_over, match_winner, round_result, result_valid}, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    r = q3.size();
    chk("rst_round_consumed", r, 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
